// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   - FSM state enum
//   - default memory geometry (MEM_BASE byte address, MEM_DEPTH words)
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int MEM_BASE  = 1024;
  localparam int MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mau_lane_align: combinational little-endian lane handling.
//   Load side : pulls the byte/half lane out of a memory word and sign- or
//               zero-extends it; word size passes the word through.
//   Store side: replaces the addressed byte/half lane of the old word with the
//               low bits of the new data; word size passes the new data.
// Ports:
//   size        in  2   request size (SZ_*)
//   is_unsigned in  1   zero-extend loads when set
//   lane        in  2   byte offset within the word (addr[1:0])
//   old_word    in  32  word read from memory
//   new_data    in  32  store data (low bytes used for sub-word)
//   load_data   out 32  extended load result
//   merged      out 32  word to write back
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    shamt     = 5'd0;
    shifted   = 32'd0;
    byte_val  = 8'd0;
    half_val  = 16'd0;
    load_data = old_word;
    merged    = new_data;
    unique case (size)
      SZ_BYTE: begin
        shamt     = {lane, 3'b000};
        shifted   = old_word >> shamt;
        byte_val  = shifted[7:0];
        load_data = {{24{~is_unsigned & byte_val[7]}}, byte_val};
        merged    = (old_word & ~(32'h0000_00FF << shamt))
                  | ({24'd0, new_data[7:0]} << shamt);
      end
      SZ_HALF: begin
        // Half lane is selected by addr[1] only; addr[0] is already clear.
        shamt     = {lane[1], 4'b0000};
        shifted   = old_word >> shamt;
        half_val  = shifted[15:0];
        load_data = {{16{~is_unsigned & half_val[15]}}, half_val};
        merged    = (old_word & ~(32'h0000_FFFF << shamt))
                  | ({16'd0, new_data[15:0]} << shamt);
      end
      default: begin
        load_data = old_word;
        merged    = new_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller in front of a word-only data memory
// (combinational read, posedge write). Accepts byte/half/word requests,
// range- and alignment-checks them, performs read-modify-write for sub-word
// stores and sign/zero extension for loads.
//
// Optional feature macro: MAU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests complete with resp_err=1
//   undefined - the low address bits are forced to alignment instead
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE outside reset. Every accepted request yields
// exactly one resp_valid pulse (with resp_err for rejected requests), unless
// rst aborts it first.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err completion pulse and result
//   mem_read, mem_write, mem_address, mem_wdata, mem_rdata   memory side
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int BASE_ADDR   = MEM_BASE,
  parameter int DEPTH_WORDS = MEM_DEPTH,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [31:0] ADDR_LO = 32'(BASE_ADDR);
  localparam logic [31:0] ADDR_HI = 32'(BASE_ADDR + 4 * DEPTH_WORDS - 1);

  state_t      state, next_state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        unsigned_q;
  logic        err_q;
  logic [31:0] word_q;

  logic        accept;
  logic        req_err;
  logic        in_range;
  logic [31:0] acc_addr;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept   = req_valid && req_ready;
  assign in_range = (req_addr >= ADDR_LO) && (req_addr <= ADDR_HI);

  // Half clears addr[0], word clears addr[1:0]; harmless when trapping since
  // a misaligned request never reaches memory in that build.
  always_comb begin
    acc_addr = req_addr;
    if (req_size == SZ_HALF) acc_addr[0]   = 1'b0;
    if (req_size == SZ_WORD) acc_addr[1:0] = 2'b00;
  end

`ifdef MAU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_err  = (req_size == SZ_ILL) || !in_range || misalign;
`else
  assign req_err  = (req_size == SZ_ILL) || !in_range;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= 32'd0;
      size_q     <= SZ_BYTE;
      wdata_q    <= 32'd0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= 32'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q     <= acc_addr;
        size_q     <= req_size;
        wdata_q    <= req_wdata;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        err_q      <= req_err;
      end
      // Old word for sub-word stores, or the load result before extension.
      if (state == ST_READ) word_q <= mem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                 next_state = ST_RESP;
          else if (req_write && req_size == SZ_WORD)   next_state = ST_WRITE;
          else                                         next_state = ST_READ;
        end
      end
      ST_READ:  next_state = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  mau_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .lane        (addr_q[1:0]),
    .old_word    (word_q),
    .new_data    (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign req_ready   = (state == ST_IDLE) && !rst;
  assign mem_read    = (state == ST_READ) && !rst;
  assign mem_write   = (state == ST_WRITE) && !rst;
  assign mem_address = ((state == ST_READ) || (state == ST_WRITE))
                     ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata   = (state == ST_WRITE) ? merged : 32'd0;
  assign resp_valid  = (state == ST_RESP) && !rst;
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = (resp_valid && !err_q && !write_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 64-word memory
// (base 0x400, combinational read, posedge write).
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // results of the most recent run_req
  int          lat;
  int          rd_cnt;
  int          wr_cnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] got_rdata;
  logic        got_err;

  logic [31:0] mem [0:63];
  logic        addr_ok;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign addr_ok   = (mem_address >= 32'h400) && (mem_address <= 32'h4FF);
  assign mem_rdata = addr_ok ? mem[mem_address[7:2]] : 32'd0;

  always @(posedge clk) begin
    if (mem_write && addr_ok) mem[mem_address[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge and watch up to 10 cycles for its response.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    int n;
    lat = 0; rd_cnt = 0; wr_cnt = 0;
    wr_addr = 32'd0; wr_data = 32'd0; got_rdata = 32'hX; got_err = 1'bX;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready before request", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 1; i <= 10; i++) begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        wr_addr = mem_address;
        wr_data = mem_wdata;
      end
      if (resp_valid) begin
        lat       = i;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  int saw_resp;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset req_ready",   {31'd0, req_ready},  32'd0);
    chk("reset resp_valid",  {31'd0, resp_valid}, 32'd0);
    chk("reset resp_err",    {31'd0, resp_err},   32'd0);
    chk("reset resp_rdata",  resp_rdata,          32'd0);
    chk("reset mem_read",    {31'd0, mem_read},   32'd0);
    chk("reset mem_write",   {31'd0, mem_write},  32'd0);
    chk("reset mem_address", mem_address,         32'd0);
    chk("reset mem_wdata",   mem_wdata,           32'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", {31'd0, req_ready}, 32'd1);

    // word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF);
    chk("sw lat",     lat,       32'd2);
    chk("sw writes",  wr_cnt,    32'd1);
    chk("sw reads",   rd_cnt,    32'd0);
    chk("sw addr",    wr_addr,   32'h400);
    chk("sw data",    wr_data,   32'hDEADBEEF);
    chk("sw err",     {31'd0, got_err}, 32'd0);
    chk("sw rdata",   got_rdata, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    chk("lw lat",     lat,       32'd2);
    chk("lw reads",   rd_cnt,    32'd1);
    chk("lw writes",  wr_cnt,    32'd0);
    chk("lw rdata",   got_rdata, 32'hDEADBEEF);

    // byte store over 0x11223344
    run_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 32'h402, 32'h123456A5);
    chk("sb lat",     lat,       32'd3);
    chk("sb reads",   rd_cnt,    32'd1);
    chk("sb writes",  wr_cnt,    32'd1);
    chk("sb addr",    wr_addr,   32'h400);
    chk("sb data",    wr_data,   32'h11A53344);
    run_req(1'b0, 2'b00, 1'b0, 32'h402, 32'd0);
    chk("lb signed",  got_rdata, 32'hFFFFFFA5);
    run_req(1'b0, 2'b00, 1'b1, 32'h402, 32'd0);
    chk("lbu",        got_rdata, 32'h000000A5);
    run_req(1'b0, 2'b00, 1'b0, 32'h403, 32'd0);
    chk("lb lane3",   got_rdata, 32'h00000011);
    run_req(1'b0, 2'b01, 1'b0, 32'h400, 32'd0);
    chk("lh lane0",   got_rdata, 32'h00003344);

    // half store over zero word
    run_req(1'b1, 2'b01, 1'b0, 32'h406, 32'hFFFF8001);
    chk("sh data",    wr_data,   32'h80010000);
    chk("sh addr",    wr_addr,   32'h404);
    run_req(1'b0, 2'b01, 1'b0, 32'h406, 32'd0);
    chk("lh signed",  got_rdata, 32'hFFFF8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h406, 32'd0);
    chk("lhu",        got_rdata, 32'h00008001);

    // last word of the range is legal
    run_req(1'b0, 2'b10, 1'b0, 32'h4FC, 32'd0);
    chk("lw top err",   {31'd0, got_err}, 32'd0);
    chk("lw top reads", rd_cnt, 32'd1);

    // error cases
    run_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0);
    chk("err low flag",  {31'd0, got_err}, 32'd1);
    chk("err low rdata", got_rdata, 32'd0);
    chk("err low lat",   lat, 32'd1);
    chk("err low mem",   rd_cnt + wr_cnt, 32'd0);
    run_req(1'b1, 2'b10, 1'b0, 32'h500, 32'h55555555);
    chk("err high flag", {31'd0, got_err}, 32'd1);
    chk("err high mem",  rd_cnt + wr_cnt, 32'd0);
    run_req(1'b0, 2'b11, 1'b0, 32'h400, 32'd0);
    chk("err size flag", {31'd0, got_err}, 32'd1);
    chk("err size rdata", got_rdata, 32'd0);
    chk("err size mem",  rd_cnt + wr_cnt, 32'd0);

    // misaligned word load
    run_req(1'b0, 2'b10, 1'b0, 32'h401, 32'd0);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("mis err",   {31'd0, got_err}, 32'd1);
    chk("mis mem",   rd_cnt, 32'd0);
`else
    chk("mis err",   {31'd0, got_err}, 32'd0);
    chk("mis rdata", got_rdata, 32'h11A53344);
`endif

    // reset during WRITE of a sub-word store
    run_req(1'b1, 2'b10, 1'b0, 32'h408, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_addr = 32'h409; req_wdata = 32'h00000077;
    @(posedge clk);            // accept -> READ
    #1 req_valid = 1'b0;
    @(posedge clk);            // READ -> WRITE
    #1 rst = 1'b1;
    #1;
    chk("rst mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst resp",      {31'd0, resp_valid}, 32'd0);
    @(posedge clk);            // reset taken, back to IDLE
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ready after", {31'd0, req_ready}, 32'd1);
    saw_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) saw_resp++;
    end
    chk("rst no resp", saw_resp, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h408, 32'd0);
    chk("rst mem unchanged", got_rdata, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
